ascon_perm_ctrl: RTL and testbench

Sequencing controller placed directly upstream of the Ascon round `permutator`. It drives the permutator's `round_i` and `input_select_i` so that one `start_i` request runs a complete p12, p8 or p6 permutation on the externally presented state. The first round loads the external state, and every following round chains the registered state back into the permutator. It signals completion with a one-cycle `done_o` pulse, aligned to the cycle in which the permutator's `state_out_o` holds the final permuted state.

---
 rtl/ascon_perm_ctrl_if.sv | 34 +++
 rtl/ascon_perm_ctrl.sv | 104 ++++++++++
 tb/tb_ascon_perm_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ascon_perm_ctrl_if.sv
// Handshake/control bundle between the Ascon permutation sequencer and its user.
// The slave side is the controller; the master side issues permutation requests.
interface ascon_perm_ctrl_if;
   logic       start_i;
   logic [1:0] mode_i;
   logic       ready_o;
   logic       busy_o;
   logic [3:0] round_o;
   logic       input_select_o;
   logic       done_o;
   logic       err_o;

   modport slave (
      input  start_i,
      input  mode_i,
      output ready_o,
      output busy_o,
      output round_o,
      output input_select_o,
      output done_o,
      output err_o
   );

   modport master (
      output start_i,
      output mode_i,
      input  ready_o,
      input  busy_o,
      input  round_o,
      input  input_select_o,
      input  done_o,
      input  err_o
   );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the Ascon permutator: runs p12/p8 (and p6 when ASCON_P6_EN
// is defined) from one start request and pulses done_o while the final state is valid.
module ascon_perm_ctrl (
   input  logic             clock_i,
   input  logic             reset_i,
   ascon_perm_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_ROUND = 4'd11;

   state_t     r_state;
   logic [3:0] r_round;
   logic       r_first;
   logic       r_err;

   state_t     w_state_nxt;
   logic [3:0] w_round_nxt;
   logic       w_first_nxt;
   logic       w_err_nxt;
   logic       w_mode_legal;
   logic [3:0] w_start_round;

   // Start round is 12-N; unlisted modes are rejected with an error pulse.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_mode_legal  = 1'b1;
      w_start_round = 4'd0;
      case (bus.mode_i)
         2'b00:   w_start_round = 4'd0;
         2'b01:   w_start_round = 4'd4;
`ifdef ASCON_P6_EN
         2'b10:   w_start_round = 4'd6;
`endif
         default: w_mode_legal  = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_round_nxt = r_round;
      w_first_nxt = 1'b0;
      w_err_nxt   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.start_i) begin
               if (w_mode_legal) begin
                  w_state_nxt = ST_RUN;
                  w_round_nxt = w_start_round;
                  w_first_nxt = 1'b1;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (r_round == LAST_ROUND) begin
               w_state_nxt = ST_DONE;
               w_round_nxt = 4'd0;
            end else begin
               w_round_nxt = r_round + 4'd1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_round_nxt = 4'd0;
         end
      endcase

      // r_round is zero outside RUN, so it drives round_o directly.
      bus.ready_o        = (r_state == ST_IDLE);
      bus.busy_o         = (r_state == ST_RUN);
      bus.done_o         = (r_state == ST_DONE);
      bus.input_select_o = (r_state == ST_RUN) && !r_first;
      bus.round_o        = r_round;
      bus.err_o          = r_err;
   end

   // NOTE: reset is synchronous and takes priority over any start request in the same edge.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         // NOTE: sequential state uses non-blocking assignments only.
         r_state <= ST_IDLE;
         r_round <= 4'd0;
         r_first <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_round <= w_round_nxt;
         r_first <= w_first_nxt;
         r_err   <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl: drives a behavioural Ascon permutator from the
// controller outputs and compares sequencing, pulses and final state against a model.
module tb_ascon_perm_ctrl;

   logic clock_i = 1'b0;
   logic reset_i;
   ascon_perm_ctrl_if bus ();

   ascon_perm_ctrl dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clock_i = ~clock_i;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string      name;
      logic [1:0] mode;
      logic       legal;
      int         start_round;
   } vec_t;

   logic [319:0] ext_state;
   logic [319:0] perm_state;

   function automatic logic [63:0] ror(logic [63:0] v, int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic logic [319:0] ascon_round(logic [319:0] s, logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      logic [7:0]  c;
      x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
      c  = {4'(4'hf - r), r};
      x2 = x2 ^ {56'd0, c};
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 ^= ror(x0, 19) ^ ror(x0, 28);
      x1 ^= ror(x1, 61) ^ ror(x1, 39);
      x2 ^= ror(x2, 1)  ^ ror(x2, 6);
      x3 ^= ror(x3, 10) ^ ror(x3, 17);
      x4 ^= ror(x4, 7)  ^ ror(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic logic [319:0] ref_perm(logic [319:0] s, int start_round);
      logic [319:0] v;
      v = s;
      for (int r = start_round; r < 12; r++) v = ascon_round(v, 4'(r));
      return v;
   endfunction

   // Behavioural permutator fed by the controller, as it sits downstream in the system.
   always @(posedge clock_i)
      perm_state <= ascon_round(bus.input_select_o ? perm_state : ext_state, bus.round_o);

   task automatic check(string name, logic [319:0] act, logic [319:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle(string tag);
      check({tag, "_ready"}, 320'(bus.ready_o), 320'(1));
      check({tag, "_busy"},  320'(bus.busy_o),  320'(0));
      check({tag, "_done"},  320'(bus.done_o),  320'(0));
      check({tag, "_err"},   320'(bus.err_o),   320'(0));
      check({tag, "_round"}, 320'(bus.round_o), 320'(0));
      check({tag, "_sel"},   320'(bus.input_select_o), 320'(0));
   endtask

   task automatic new_ext_state();
      for (int i = 0; i < 10; i++) ext_state[i*32 +: 32] = $urandom;
   endtask

   // Issue one request from IDLE and follow it cycle by cycle until IDLE again.
   task automatic run_req(vec_t v);
      int n;
      n = 12 - v.start_round;
      new_ext_state();
      @(negedge clock_i);
      check({v.name, "_ready_pre"}, 320'(bus.ready_o), 320'(1));
      bus.start_i = 1'b1;
      bus.mode_i  = v.mode;
      @(negedge clock_i);
      bus.start_i = 1'b0;
      bus.mode_i  = 2'b11;  // scrambled mode must not disturb the latched run
      if (v.legal) begin
         for (int k = 1; k <= n; k++) begin
            check($sformatf("%s_round_c%0d", v.name, k), 320'(bus.round_o), 320'(v.start_round + k - 1));
            check($sformatf("%s_sel_c%0d", v.name, k), 320'(bus.input_select_o), 320'(k != 1));
            check($sformatf("%s_busy_c%0d", v.name, k), 320'(bus.busy_o), 320'(1));
            check($sformatf("%s_done_c%0d", v.name, k), 320'(bus.done_o), 320'(0));
            check($sformatf("%s_ready_c%0d", v.name, k), 320'(bus.ready_o), 320'(0));
            @(negedge clock_i);
         end
         check({v.name, "_done"},       320'(bus.done_o),  320'(1));
         check({v.name, "_done_busy"},  320'(bus.busy_o),  320'(0));
         check({v.name, "_done_ready"}, 320'(bus.ready_o), 320'(0));
         check({v.name, "_done_round"}, 320'(bus.round_o), 320'(0));
         check({v.name, "_done_sel"},   320'(bus.input_select_o), 320'(0));
         check({v.name, "_state"},      perm_state, ref_perm(ext_state, v.start_round));
         @(negedge clock_i);
         check_idle({v.name, "_after"});
      end else begin
         check({v.name, "_err"},   320'(bus.err_o),   320'(1));
         check({v.name, "_ready"}, 320'(bus.ready_o), 320'(1));
         check({v.name, "_busy"},  320'(bus.busy_o),  320'(0));
         @(negedge clock_i);
         check_idle({v.name, "_after"});
      end
   endtask

   initial begin
      vec_t vecs[5];
      int   done_cnt, first_done, second_done;

      vecs[0] = '{name: "p12",   mode: 2'b00, legal: 1'b1, start_round: 0};
      vecs[1] = '{name: "p8",    mode: 2'b01, legal: 1'b1, start_round: 4};
`ifdef ASCON_P6_EN
      vecs[2] = '{name: "p6",    mode: 2'b10, legal: 1'b1, start_round: 6};
`else
      vecs[2] = '{name: "p6off", mode: 2'b10, legal: 1'b0, start_round: 0};
`endif
      vecs[3] = '{name: "m11",   mode: 2'b11, legal: 1'b0, start_round: 0};
      vecs[4] = '{name: "p12b",  mode: 2'b00, legal: 1'b1, start_round: 0};

      reset_i     = 1'b1;
      bus.start_i = 1'b0;
      bus.mode_i  = 2'b00;
      ext_state   = '0;
      repeat (3) @(negedge clock_i);
      check_idle("reset");
      reset_i = 1'b0;
      @(negedge clock_i);
      check_idle("post_reset");

      for (int i = 0; i < 5; i++) run_req(vecs[i]);

      // start_i held high: accepts every 14 cycles, ignored during RUN and DONE.
      done_cnt = 0; first_done = -1; second_done = -1;
      bus.start_i = 1'b1;
      bus.mode_i  = 2'b00;
      for (int t = 1; t <= 28; t++) begin
         @(negedge clock_i);
         if (t == 2)  check("b2b_run_ignore", 320'(bus.round_o), 320'(1));
         if (t == 13) check("b2b_done_ignore_ready", 320'(bus.ready_o), 320'(0));
         if (t == 14) check("b2b_idle_gap", 320'(bus.ready_o), 320'(1));
         if (t == 15) check("b2b_restart_round", 320'(bus.round_o), 320'(0));
         if (bus.done_o) begin
            done_cnt++;
            if (first_done < 0) first_done = t;
            else second_done = t;
         end
         if (t == 28) bus.start_i = 1'b0;
      end
      check("b2b_done_count", 320'(done_cnt), 320'(2));
      check("b2b_first_done", 320'(first_done), 320'(13));
      check("b2b_second_done", 320'(second_done), 320'(27));
      @(negedge clock_i);
      check("b2b_stopped", 320'(bus.busy_o), 320'(0));

      // Reset during round 5 of p12 aborts without a done pulse.
      @(negedge clock_i);
      bus.start_i = 1'b1;
      bus.mode_i  = 2'b00;
      @(negedge clock_i);
      bus.start_i = 1'b0;
      repeat (5) @(negedge clock_i);
      check("abort_at_round5", 320'(bus.round_o), 320'(5));
      reset_i = 1'b1;
      @(negedge clock_i);
      reset_i = 1'b0;
      check_idle("abort");
      done_cnt = 0;
      for (int t = 0; t < 16; t++) begin
         @(negedge clock_i);
         if (bus.done_o || bus.busy_o) done_cnt++;
      end
      check("abort_no_done", 320'(done_cnt), 320'(0));
      run_req(vecs[1]);

      // Reset and start in the same cycle: the request is dropped.
      @(negedge clock_i);
      reset_i     = 1'b1;
      bus.start_i = 1'b1;
      bus.mode_i  = 2'b00;
      @(negedge clock_i);
      reset_i     = 1'b0;
      bus.start_i = 1'b0;
      check_idle("rst_start");
      @(negedge clock_i);
      check("rst_start_dropped", 320'(bus.busy_o), 320'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
